// File: rtl/debounce.sv
// debounce: per-channel two-flop synchronizer and counter-based debouncer.
// Emits a clean level plus registered one-cycle rise/fall pulses.
module debounce #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Bring raw asynchronous inputs into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lvl_q;
    logic             rise_q;
    logic             fall_q;
    logic             smp;

    assign smp = s2[g];

    // Count consecutive contrary samples; commit on the last one.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= STABLE_LO;
        cnt    <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        unique case (state)
          STABLE_LO: begin
            if (smp) begin
              state <= WAIT_HI;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          WAIT_HI: begin
            if (!smp) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state  <= STABLE_HI;
              lvl_q  <= 1'b1;
              rise_q <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          STABLE_HI: begin
            if (!smp) begin
              state <= WAIT_LO;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          WAIT_LO: begin
            if (smp) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state  <= STABLE_LO;
              lvl_q  <= 1'b0;
              fall_q <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign dout[g] = lvl_q;
    assign rise[g] = rise_q;
    assign fall[g] = fall_q;
  end

endmodule

// File: tb/tb_debounce.sv
// tb_debounce: randomized and directed stimulus against a run-length model.
// Expected outputs are queued per edge and checked by a separate monitor.
module tb_debounce;

  localparam int W  = 2;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = 2'b11;
  logic [W-1:0] dout;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  always #5 clk = ~clk;

  debounce #(
    .WIDTH(W),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .rise(rise),
    .fall(fall)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rc[W];
  int   fc[W];

  // Reference: input seen two edges late; a level is accepted after
  // SC consecutive samples that disagree with the current output.
  logic [W-1:0] m_d1 = '0;
  logic [W-1:0] m_d2 = '0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_smp;
  int           m_run[W];
  exp_t         m_e;

  initial begin
    for (int i = 0; i < W; i++) begin
      m_run[i] = 0;
      rc[i] = 0;
      fc[i] = 0;
    end
  end

  always @(posedge clk) begin
    m_e.r = '0;
    m_e.f = '0;
    if (rst) begin
      m_d1 = '0;
      m_d2 = '0;
      m_out = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_smp = m_d2;
      m_d2 = m_d1;
      m_d1 = din;
      for (int i = 0; i < W; i++) begin
        if (m_smp[i] != m_out[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == SC) begin
            m_run[i] = 0;
            m_out[i] = m_smp[i];
            if (m_smp[i]) m_e.r[i] = 1'b1;
            else m_e.f[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_e.d = m_out;
    exp_q.push_back(m_e);
  end

  exp_t got;
  exp_t want;

  always @(posedge clk) begin
    #1;
    got = '{d: dout, r: rise, f: fall};
    for (int i = 0; i < W; i++) begin
      if (rise[i] === 1'b1) rc[i]++;
      if (fall[i] === 1'b1) fc[i]++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t actual=%b", $time, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t actual d=%b r=%b f=%b required d=%b r=%b f=%b",
                 $time, got.d, got.r, got.f, want.d, want.r, want.f);
      end
    end
  end

  task automatic check_eq(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  int r0, r1, f0, f1;

  task automatic snap();
    r0 = rc[0]; r1 = rc[1];
    f0 = fc[0]; f1 = fc[1];
  endtask

  initial begin
    // 1: reset with inputs high
    cyc(3);
    check_eq("reset_dout", int'(dout), 0);
    check_eq("reset_pulses", int'({rise, fall}), 0);
    snap();
    rst = 1'b0;
    cyc(10);
    check_eq("rst_rel_rise0", rc[0] - r0, 1);
    check_eq("rst_rel_rise1", rc[1] - r1, 1);
    check_eq("rst_rel_dout", int'(dout), 3);
    din = 2'b00;
    cyc(10);
    check_eq("both_low", int'(dout), 0);

    // 2: clean press on channel 0
    snap();
    din = 2'b01;
    cyc(20);
    check_eq("press_rise0", rc[0] - r0, 1);
    check_eq("press_ch1_quiet", (rc[1] - r1) + (fc[1] - f1), 0);
    check_eq("press_dout", int'(dout), 1);
    din = 2'b00;
    cyc(10);

    // 3: glitch rejection
    snap();
    din = 2'b01;
    cyc(3);
    din = 2'b00;
    cyc(12);
    check_eq("glitch_pulses", (rc[0] - r0) + (fc[0] - f0), 0);
    check_eq("glitch_dout", int'(dout), 0);

    // 4: bounce then stable
    snap();
    for (int k = 0; k < 5; k++) begin
      din[0] = (k % 2 == 0);
      cyc(2);
    end
    din[0] = 1'b1;
    cyc(15);
    check_eq("bounce_rise0", rc[0] - r0, 1);
    check_eq("bounce_fall0", fc[0] - f0, 0);

    // 5: release with concurrent press
    snap();
    din = 2'b10;
    cyc(12);
    check_eq("swap_fall0", fc[0] - f0, 1);
    check_eq("swap_rise1", rc[1] - r1, 1);
    check_eq("swap_dout", int'(dout), 2);
    din = 2'b00;
    cyc(10);

    // 6: reset mid-count
    snap();
    din[0] = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_eq("midrst_no_pulse", rc[0] - r0, 0);
    cyc(12);
    check_eq("midrst_rise0", rc[0] - r0, 1);
    din = 2'b00;
    cyc(10);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(5) == 0) din[i] = ~din[i];
      rst = ($urandom_range(299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
